// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two requesters (req0 = EX stage,
//   req1 = auxiliary unit). One op is in flight at a time: it is accepted
//   over valid/ready, its operands/control are registered onto the ALU
//   inputs and held there, and the ALU result comes back as a one-cycle
//   response pulse tagged with the requester id.
//
//   MUL is a multi-cycle path: its inputs are held for MUL_CYCLES cycles.
//   Every other control code takes a single cycle.
//
//   Build option: define ALU_ARB_FIXED_PRIO_EN to make req0 win every tie
//   (req1 may starve). Left undefined, ties alternate round-robin.
//
// Handshake: a requester's op transfers on a rising edge where its valid and
//   ready are both 1. Ready only depends on the arbiter state and this
//   cycle's valids (never on the requester's own ready), and a requester may
//   withdraw valid before it is accepted; payload is sampled only on the
//   transfer edge.

`ifndef AND
`define AND 3'b000
`endif
`ifndef OR
`define OR  3'b001
`endif
`ifndef ADD
`define ADD 3'b010
`endif
`ifndef MUL
`define MUL 3'b011
`endif
`ifndef SUB
`define SUB 3'b110
`endif

module alu_share_arbiter #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_ctrl_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,

  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_ctrl_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,

  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  output logic [2:0]       alu_ctrl_o,
  input  logic [WIDTH-1:0] alu_data_i,
  input  logic             alu_zero_i,

  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  output logic             rsp_zero_o,

  output logic             dbg_state_o,
  output logic [3:0]       dbg_cnt_o
);

  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_EXEC = 1'b1;

  // Down-counter start value for a MUL; the op completes when it reaches 0.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_CYCLES - 1);

  logic             state_q;
  logic [3:0]       cnt_q;
  logic             id_q;

  logic             tie_pick1;
  logic             grant0;
  logic             grant1;
  logic             handshake;
  logic             done;
  logic [2:0]       sel_ctrl;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [3:0]       load_cnt;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // req0 always wins a tie.
  assign tie_pick1 = 1'b0;
`else
  logic last_grant_q;

  // Round-robin: on a tie, grant whoever did not win last time.
  assign tie_pick1 = ~last_grant_q;
`endif

  // Grant: the only valid requester, or the tie-break winner when both ask.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant0 = ~tie_pick1;
      grant1 = tie_pick1;
    end else begin
      grant0 = req0_valid_i;
      grant1 = req1_valid_i;
    end
  end

  assign req0_ready_o = (state_q == STATE_IDLE) & grant0;
  assign req1_ready_o = (state_q == STATE_IDLE) & grant1;
  assign handshake    = req0_ready_o | req1_ready_o;

  // Payload of the granted requester (only meaningful on a handshake).
  always_comb begin
    sel_ctrl = req0_ctrl_i;
    sel_a    = req0_a_i;
    sel_b    = req0_b_i;
    if (grant1) begin
      sel_ctrl = req1_ctrl_i;
      sel_a    = req1_a_i;
      sel_b    = req1_b_i;
    end
  end

  assign load_cnt = (sel_ctrl == `MUL) ? MUL_CNT_INIT : 4'd0;

  // The op finishes on the EXEC edge where the counter has run down to 0.
  assign done = (state_q == STATE_EXEC) && (cnt_q == 4'd0);

  assign dbg_state_o = state_q;
  assign dbg_cnt_o   = cnt_q;

  // Control FSM: IDLE accepts an op, EXEC counts its hold cycles down.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= STATE_IDLE;
      cnt_q   <= 4'd0;
      id_q    <= 1'b0;
    end else begin
      case (state_q)
        STATE_IDLE: begin
          if (handshake) begin
            state_q <= STATE_EXEC;
            cnt_q   <= load_cnt;
            id_q    <= grant1;
          end
        end
        STATE_EXEC: begin
          if (cnt_q == 4'd0) begin
            state_q <= STATE_IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= STATE_IDLE;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // ALU input registers: loaded on a handshake, otherwise held steady.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_data1_o <= '0;
      alu_data2_o <= '0;
      alu_ctrl_o  <= 3'd0;
    end else if (handshake) begin
      alu_data1_o <= sel_a;
      alu_data2_o <= sel_b;
      alu_ctrl_o  <= sel_ctrl;
    end
  end

  // Response: one-cycle valid pulse; data/zero/id hold until the next one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= 1'b0;
      rsp_data_o  <= '0;
      rsp_zero_o  <= 1'b0;
    end else begin
      rsp_valid_o <= done;
      if (done) begin
        rsp_id_o   <= id_q;
        rsp_data_o <= alu_data_i;
        rsp_zero_o <= alu_zero_i;
      end
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Remember the last winner; reset value 1 makes req0 win the first tie.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_grant_q <= 1'b1;
    end else if (handshake) begin
      last_grant_q <= grant1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter. A small behavioural ALU sits on
//   the alu_* ports; expected responses are hand-computed and queued in
//   exp_q, and a monitor pops one per response pulse.

`ifndef AND
`define AND 3'b000
`endif
`ifndef OR
`define OR  3'b001
`endif
`ifndef ADD
`define ADD 3'b010
`endif
`ifndef MUL
`define MUL 3'b011
`endif
`ifndef SUB
`define SUB 3'b110
`endif

module tb_alu_share_arbiter;

  localparam int WIDTH      = 32;
  localparam int MUL_CYCLES = 3;

  logic             clk_i;
  logic             rst_i;
  logic             req0_valid_i;
  logic             req0_ready_o;
  logic [2:0]       req0_ctrl_i;
  logic [WIDTH-1:0] req0_a_i;
  logic [WIDTH-1:0] req0_b_i;
  logic             req1_valid_i;
  logic             req1_ready_o;
  logic [2:0]       req1_ctrl_i;
  logic [WIDTH-1:0] req1_a_i;
  logic [WIDTH-1:0] req1_b_i;
  logic [WIDTH-1:0] alu_data1_o;
  logic [WIDTH-1:0] alu_data2_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_data_i;
  logic             alu_zero_i;
  logic             rsp_valid_o;
  logic             rsp_id_o;
  logic [WIDTH-1:0] rsp_data_o;
  logic             rsp_zero_o;
  logic             dbg_state_o;
  logic [3:0]       dbg_cnt_o;

  int checks   = 0;
  int failures = 0;

  // Expected responses: {id, zero, data}.
  logic [WIDTH+1:0] exp_q[$];
  logic [WIDTH+1:0] mon_e;

  alu_share_arbiter #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_ready_o (req0_ready_o),
    .req0_ctrl_i  (req0_ctrl_i),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_valid_i (req1_valid_i),
    .req1_ready_o (req1_ready_o),
    .req1_ctrl_i  (req1_ctrl_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .alu_data1_o  (alu_data1_o),
    .alu_data2_o  (alu_data2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_data_i   (alu_data_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_zero_o   (rsp_zero_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_cnt_o    (dbg_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural ALU ----------------
  always_comb begin
    case (alu_ctrl_o)
      `AND:    alu_data_i = alu_data1_o & alu_data2_o;
      `OR:     alu_data_i = alu_data1_o | alu_data2_o;
      `ADD:    alu_data_i = alu_data1_o + alu_data2_o;
      `SUB:    alu_data_i = alu_data1_o - alu_data2_o;
      `MUL:    alu_data_i = alu_data1_o * alu_data2_o;
      default: alu_data_i = '0;
    endcase
    alu_zero_i = (alu_data1_o == alu_data2_o);
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    req0_valid_i = v;
    req0_ctrl_i  = c;
    req0_a_i     = a;
    req0_b_i     = b;
  endtask

  task automatic drive1(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    req1_valid_i = v;
    req1_ctrl_i  = c;
    req1_a_i     = a;
    req1_b_i     = b;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk_i) begin
    if (rst_i && rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id",   64'(rsp_id_o),   64'(mon_e[WIDTH+1]));
        check("rsp_zero", 64'(rsp_zero_o), 64'(mon_e[WIDTH]));
        check("rsp_data", 64'(rsp_data_o), 64'(mon_e[WIDTH-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : main
    logic found;
    logic gid;
    logic exp_gid;
    int   t;

    rst_i = 1'b0;
    drive0(1'b0, 3'd0, '0, '0);
    drive1(1'b0, 3'd0, '0, '0);
    step();
    step();

    // 1. reset state
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rdy0",      64'(req0_ready_o), 64'd0);
    check("rst_rdy1",      64'(req1_ready_o), 64'd0);
    check("rst_alu_d1",    64'(alu_data1_o), 64'd0);
    check("rst_alu_d2",    64'(alu_data2_o), 64'd0);
    check("rst_alu_ctrl",  64'(alu_ctrl_o), 64'd0);
    check("rst_rsp_data",  64'(rsp_data_o), 64'd0);
    check("rst_rsp_id",    64'(rsp_id_o), 64'd0);
    check("rst_rsp_zero",  64'(rsp_zero_o), 64'd0);
    check("rst_state",     64'(dbg_state_o), 64'd0);
    rst_i = 1'b1;
    step();

    // 2. req0 ADD 5+7 alone
    drive0(1'b1, `ADD, 32'd5, 32'd7);
    #1;
    check("add_rdy0", 64'(req0_ready_o), 64'd1);
    check("add_rdy1", 64'(req1_ready_o), 64'd0);
    exp_q.push_back({1'b0, 1'b0, 32'd12});
    step();
    drive0(1'b0, `ADD, 32'd0, 32'd0);
    check("add_state",   64'(dbg_state_o), 64'd1);
    check("add_alu_d1",  64'(alu_data1_o), 64'd5);
    check("add_alu_d2",  64'(alu_data2_o), 64'd7);
    check("add_alu_ctrl",64'(alu_ctrl_o), 64'(`ADD));
    check("add_busy",    64'(rsp_valid_o), 64'd0);
    step();
    check("add_latency", 64'(rsp_valid_o), 64'd1);
    step();
    check("add_pulse",   64'(rsp_valid_o), 64'd0);
    check("add_hold",    64'(rsp_data_o), 64'd12);

    // 3. req1 MUL 6*7, req0 asks while the MUL is executing
    drive1(1'b1, `MUL, 32'd6, 32'd7);
    #1;
    check("mul_rdy1", 64'(req1_ready_o), 64'd1);
    check("mul_rdy0", 64'(req0_ready_o), 64'd0);
    exp_q.push_back({1'b1, 1'b0, 32'd42});
    for (int i = 1; i <= MUL_CYCLES; i++) begin
      step();
      if (i == 1) begin
        drive1(1'b0, `ADD, 32'd0, 32'd0);
        drive0(1'b1, `ADD, 32'd1, 32'd1);
      end
      #1;
      check($sformatf("mul_busy_rdy0_%0d", i), 64'(req0_ready_o), 64'd0);
      check($sformatf("mul_busy_rdy1_%0d", i), 64'(req1_ready_o), 64'd0);
      check($sformatf("mul_cnt_%0d", i),  64'(dbg_cnt_o), 64'(MUL_CYCLES - i));
      check($sformatf("mul_hold_d1_%0d", i), 64'(alu_data1_o), 64'd6);
      check($sformatf("mul_hold_d2_%0d", i), 64'(alu_data2_o), 64'd7);
      check($sformatf("mul_hold_ctrl_%0d", i), 64'(alu_ctrl_o), 64'(`MUL));
      check($sformatf("mul_no_rsp_%0d", i), 64'(rsp_valid_o), 64'd0);
      if (i == MUL_CYCLES) drive0(1'b0, `ADD, 32'd0, 32'd0);
    end
    step();
    check("mul_latency", 64'(rsp_valid_o), 64'd1);

    // 4. both requesters continuously valid with SUB ops
    drive0(1'b1, `SUB, 32'd9, 32'd9);
    drive1(1'b1, `SUB, 32'd3, 32'd5);
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      gid   = 1'b0;
      t     = 0;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_gid = 1'b0;
`else
      exp_gid = g[0];
`endif
      while (!found && t < 4) begin
        #1;
        if (req0_ready_o || req1_ready_o) begin
          found = 1'b1;
          gid   = req1_ready_o;
          if (gid) exp_q.push_back({1'b1, 1'b0, 32'hFFFF_FFFE});
          else     exp_q.push_back({1'b0, 1'b1, 32'h0000_0000});
        end
        step();
        t++;
      end
      check($sformatf("rr_found_%0d", g), 64'(found), 64'd1);
      check($sformatf("rr_grant_%0d", g), 64'(gid), 64'(exp_gid));
    end
    drive0(1'b0, `ADD, 32'd0, 32'd0);
    drive1(1'b0, `ADD, 32'd0, 32'd0);
    step();
    step();
    check("rr_drained", 64'(exp_q.size()), 64'd0);

    // 5. reset in cycle 2 of a req0 MUL; op is dropped, req0 wins next tie
    drive0(1'b1, `MUL, 32'd2, 32'd3);
    #1;
    check("rmul_rdy0", 64'(req0_ready_o), 64'd1);
    step();
    drive0(1'b0, `ADD, 32'd0, 32'd0);
    step();
    rst_i = 1'b0;
    #1;
    check("rmid_alu_d1",   64'(alu_data1_o), 64'd0);
    check("rmid_alu_d2",   64'(alu_data2_o), 64'd0);
    check("rmid_alu_ctrl", 64'(alu_ctrl_o), 64'd0);
    check("rmid_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rmid_rsp_id",   64'(rsp_id_o), 64'd0);
    check("rmid_state",    64'(dbg_state_o), 64'd0);
    check("rmid_cnt",      64'(dbg_cnt_o), 64'd0);
    step();
    rst_i = 1'b1;
    for (int i = 0; i < 6; i++) step();
    drive0(1'b1, `ADD, 32'd1, 32'd1);
    drive1(1'b1, `ADD, 32'd4, 32'd4);
    #1;
    check("prst_grant0_rdy0", 64'(req0_ready_o), 64'd1);
    check("prst_grant0_rdy1", 64'(req1_ready_o), 64'd0);
    exp_q.push_back({1'b0, 1'b1, 32'd2});
    step();
    drive0(1'b0, `ADD, 32'd0, 32'd0);
    step();
    #1;
    check("prst_grant1_rdy1", 64'(req1_ready_o), 64'd1);
    exp_q.push_back({1'b1, 1'b1, 32'd8});
    step();
    drive1(1'b0, `ADD, 32'd0, 32'd0);
    step();
    step();

    // 6. back-to-back req0 ops with no bubble
    drive0(1'b1, `OR, 32'h0000_00F0, 32'h0000_000F);
    #1;
    check("b2b_rdy_first", 64'(req0_ready_o), 64'd1);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_00FF});
    step();
    drive0(1'b1, `AND, 32'h0000_00FF, 32'h0000_003C);
    #1;
    check("b2b_busy", 64'(req0_ready_o), 64'd0);
    step();
    check("b2b_rsp",   64'(rsp_valid_o), 64'd1);
    check("b2b_ready", 64'(req0_ready_o), 64'd1);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_003C});
    step();
    drive0(1'b0, `ADD, 32'd0, 32'd0);
    check("b2b_alu_ctrl", 64'(alu_ctrl_o), 64'(`AND));
    check("b2b_alu_d1",   64'(alu_data1_o), 64'h0000_00FF);
    step();
    check("b2b_rsp2", 64'(rsp_valid_o), 64'd1);
    step();

    // 7. undefined control code is a 1-cycle op returning 0
    drive1(1'b1, 3'b111, 32'd3, 32'd3);
    #1;
    check("undef_rdy1", 64'(req1_ready_o), 64'd1);
    exp_q.push_back({1'b1, 1'b1, 32'd0});
    step();
    drive1(1'b0, `ADD, 32'd0, 32'd0);
    step();
    check("undef_rsp", 64'(rsp_valid_o), 64'd1);
    step();
    step();

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
